// File: rtl/iic_cfg_seq.sv
// Table-driven configuration sequencer: walks a synchronous config ROM and issues
// one iic_drive transaction per entry, with retry on NACK/verify mismatch.
module iic_cfg_seq #(
  parameter logic [7:0] DEV_ADDR  = 8'h78,
  parameter int         TBL_AW    = 8,
  parameter int         MAX_RETRY = 3,
  parameter int         BUSY_TO   = 16
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              cfg_start,
  output logic [TBL_AW-1:0] tbl_addr,
  input  logic [25:0]       tbl_data,
  output logic              drv_start_en,
  output logic              drv_wr_rd_flag,
  output logic [7:0]        drv_dev_addr,
  output logic [15:0]       drv_register,
  output logic [7:0]        drv_data_byte,
  input  logic              drv_busy,
  input  logic              drv_err,
  input  logic [7:0]        drv_rd_data,
  output logic              cfg_busy,
  output logic              cfg_done,
  output logic              cfg_fail,
  output logic [TBL_AW-1:0] fail_idx
);

  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam int TW = $clog2(BUSY_TO + 1);
  localparam logic [RW-1:0]     RETRY_LIM = RW'(MAX_RETRY);
  localparam logic [TW-1:0]     TO_LAST   = TW'(BUSY_TO - 1);
  localparam logic [TBL_AW-1:0] TBL_LAST  = '1;

  localparam logic [1:0] OP_WR  = 2'b00;
  localparam logic [1:0] OP_RD  = 2'b01;
  localparam logic [1:0] OP_DLY = 2'b10;

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, ISSUE, WAIT_HI, WAIT_LO, CHECK, DELAY, DONE, FAIL
  } state_t;

  state_t          state;
  logic [RW-1:0]   retry;
  logic [TW-1:0]   to_cnt;
  logic [15:0]     dly_cnt;
  logic [1:0]      entry_op;
  logic [7:0]      entry_data;
  logic            xact_bad;
  logic            adv;
  logic            retry_req;

  assign drv_dev_addr = DEV_ADDR;
  assign xact_bad = drv_err || ((entry_op == OP_RD) && (drv_rd_data != entry_data));

  // adv: step to the next table entry; retry_req: the current entry failed an attempt
  always_comb begin
    adv       = 1'b0;
    retry_req = 1'b0;
    case (state)
      DECODE:  adv = (tbl_data[25:24] == OP_DLY) && (tbl_data[23:8] == 16'd0);
      DELAY:   adv = (dly_cnt == 16'd1);
      CHECK: begin
        adv       = !xact_bad;
        retry_req = xact_bad;
      end
      WAIT_HI: retry_req = !drv_busy && (to_cnt == TO_LAST);
      default: begin
        adv       = 1'b0;
        retry_req = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state          <= IDLE;
      tbl_addr       <= '0;
      fail_idx       <= '0;
      retry          <= '0;
      to_cnt         <= '0;
      dly_cnt        <= '0;
      entry_op       <= OP_WR;
      entry_data     <= '0;
      drv_start_en   <= 1'b0;
      drv_wr_rd_flag <= 1'b0;
      drv_register   <= '0;
      drv_data_byte  <= '0;
      cfg_busy       <= 1'b0;
      cfg_done       <= 1'b0;
      cfg_fail       <= 1'b0;
    end else begin
      cfg_done <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_start) begin
            tbl_addr <= '0;
            retry    <= '0;
            cfg_fail <= 1'b0;
            cfg_busy <= 1'b1;
            state    <= FETCH;
          end
        end
        FETCH: state <= DECODE;
        DECODE: begin
          entry_op   <= tbl_data[25:24];
          entry_data <= tbl_data[7:0];
          case (tbl_data[25:24])
            OP_WR: begin
              drv_register   <= tbl_data[23:8];
              drv_data_byte  <= tbl_data[7:0];
              drv_wr_rd_flag <= 1'b0;
              state          <= ISSUE;
            end
            OP_RD: begin
              drv_register   <= tbl_data[23:8];
              drv_wr_rd_flag <= 1'b1;
              state          <= ISSUE;
            end
            OP_DLY: begin
              dly_cnt <= tbl_data[23:8];
              state   <= DELAY;
            end
            default: begin
              cfg_done <= 1'b1;
              cfg_busy <= 1'b0;
              state    <= DONE;
            end
          endcase
        end
        ISSUE: begin
          drv_start_en <= 1'b1;
          to_cnt       <= '0;
          state        <= WAIT_HI;
        end
        WAIT_HI: begin
          if (drv_busy) begin
            drv_start_en <= 1'b0;
            state        <= WAIT_LO;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        WAIT_LO: if (!drv_busy) state <= CHECK;
        CHECK:   state <= CHECK;
        DELAY:   dly_cnt <= dly_cnt - 16'd1;
        DONE:    state <= IDLE;
        FAIL:    state <= IDLE;
        default: state <= IDLE;
      endcase

      // Running off the end of the table without an end marker is a failure
      if (adv) begin
        if (tbl_addr == TBL_LAST) begin
          fail_idx <= TBL_LAST;
          cfg_fail <= 1'b1;
          cfg_busy <= 1'b0;
          state    <= FAIL;
        end else begin
          tbl_addr <= tbl_addr + 1'b1;
          retry    <= '0;
          state    <= FETCH;
        end
      end

      if (retry_req) begin
        drv_start_en <= 1'b0;
        if (retry < RETRY_LIM) begin
          retry <= retry + 1'b1;
          state <= ISSUE;
        end else begin
          fail_idx <= tbl_addr;
          cfg_fail <= 1'b1;
          cfg_busy <= 1'b0;
          state    <= FAIL;
        end
      end
    end
  end

endmodule

// File: tb/tb_iic_cfg_seq.sv
// Directed bench for iic_cfg_seq: behavioural ROM and I2C driver model, checks
// issue counts, handshake timing, retries, delay spacing, reset and table wrap.
module tb_iic_cfg_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_start;
  logic [7:0]  tbl_addr;
  logic [25:0] tbl_data;
  logic        drv_start_en;
  logic        drv_wr_rd_flag;
  logic [7:0]  drv_dev_addr;
  logic [15:0] drv_register;
  logic [7:0]  drv_data_byte;
  logic        drv_busy;
  logic        drv_err;
  logic [7:0]  drv_rd_data;
  logic        cfg_busy;
  logic        cfg_done;
  logic        cfg_fail;
  logic [7:0]  fail_idx;

  always #5 clk = ~clk;

  iic_cfg_seq dut (
    .clk_i          (clk),
    .rst_n          (rst_n),
    .cfg_start      (cfg_start),
    .tbl_addr       (tbl_addr),
    .tbl_data       (tbl_data),
    .drv_start_en   (drv_start_en),
    .drv_wr_rd_flag (drv_wr_rd_flag),
    .drv_dev_addr   (drv_dev_addr),
    .drv_register   (drv_register),
    .drv_data_byte  (drv_data_byte),
    .drv_busy       (drv_busy),
    .drv_err        (drv_err),
    .drv_rd_data    (drv_rd_data),
    .cfg_busy       (cfg_busy),
    .cfg_done       (cfg_done),
    .cfg_fail       (cfg_fail),
    .fail_idx       (fail_idx)
  );

  logic [25:0] rom [0:255];
  always @(posedge clk) tbl_data <= rom[tbl_addr];

  // Driver model: busy one cycle after start_en, busy for 4 cycles
  int         m_issue = 0;
  int         m_cnt;
  logic       m_active;
  logic [7:0] rd_val;
  int         nack_lo;
  int         nack_hi;
  logic       never;

  always @(posedge clk) begin
    if (!rst_n) begin
      drv_busy    <= 1'b0;
      m_active    <= 1'b0;
      m_cnt       <= 0;
      drv_err     <= 1'b0;
      drv_rd_data <= 8'h00;
    end else if (m_active) begin
      if (m_cnt == 0) begin
        drv_busy    <= 1'b0;
        m_active    <= 1'b0;
        drv_err     <= (m_issue >= nack_lo) && (m_issue <= nack_hi);
        drv_rd_data <= rd_val;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end else if (drv_start_en && !never) begin
      m_active <= 1'b1;
      drv_busy <= 1'b1;
      m_cnt    <= 3;
      m_issue  <= m_issue + 1;
    end
  end

  int          cyc = 0;
  int          n_starts = 0;
  int          n_done = 0;
  int          se_hi = 0;
  logic        prev_se = 1'b0;
  logic [15:0] st_reg [0:255];
  logic [7:0]  st_dat [0:255];
  logic        st_wr  [0:255];
  int          st_cyc [0:255];

  always @(negedge clk) begin
    cyc     <= cyc + 1;
    prev_se <= drv_start_en;
    if (drv_start_en === 1'b1) se_hi <= se_hi + 1;
    if (drv_start_en === 1'b1 && prev_se !== 1'b1) begin
      n_starts                <= n_starts + 1;
      st_reg[n_starts[7:0]]   <= drv_register;
      st_dat[n_starts[7:0]]   <= drv_data_byte;
      st_wr[n_starts[7:0]]    <= drv_wr_rd_flag;
      st_cyc[n_starts[7:0]]   <= cyc;
    end
    if (cfg_done === 1'b1) n_done <= n_done + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [25:0] w(input logic [1:0] op, input logic [15:0] r, input logic [7:0] d);
    return {op, r, d};
  endfunction

  task automatic fill(input logic [25:0] v);
    for (int i = 0; i < 256; i++) rom[i] = v;
  endtask

  task automatic run_cfg(input string tag);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (cfg_busy === 1'b0) break;
      tick();
    end
    chk({tag, "_busy_drop"}, cfg_busy, 1'b0);
    tick();
    tick();
  endtask

  int s0, d0, h0, base, gap;

  initial begin
    rst_n = 1'b0; cfg_start = 1'b0; rd_val = 8'h00;
    nack_lo = 1; nack_hi = 0; never = 1'b0;
    fill(w(2'b11, 16'h0000, 8'h00));
    repeat (3) tick();
    chk("rst_start_en", drv_start_en, 1'b0);
    chk("rst_busy",     cfg_busy, 1'b0);
    chk("rst_done",     cfg_done, 1'b0);
    chk("rst_fail",     cfg_fail, 1'b0);
    chk("rst_addr",     tbl_addr, 8'h00);
    chk("rst_fail_idx", fail_idx, 8'h00);
    chk("rst_reg",      drv_register, 16'h0000);
    chk("rst_data",     drv_data_byte, 8'h00);
    chk("rst_wr",       drv_wr_rd_flag, 1'b0);
    chk("dev_addr",     drv_dev_addr, 8'h78);
    rst_n = 1'b1;
    tick();

    // single write then end
    rom[0] = w(2'b00, 16'h3008, 8'h82); rom[1] = w(2'b11, 16'h0000, 8'h00);
    s0 = n_starts; d0 = n_done;
    run_cfg("wr1");
    chk("wr1_starts", n_starts - s0, 1);
    chk("wr1_reg",    st_reg[s0[7:0]], 16'h3008);
    chk("wr1_data",   st_dat[s0[7:0]], 8'h82);
    chk("wr1_flag",   st_wr[s0[7:0]], 1'b0);
    chk("wr1_done",   n_done - d0, 1);
    chk("wr1_fail",   cfg_fail, 1'b0);

    // read-verify, matching
    rom[0] = w(2'b01, 16'h300A, 8'h56); rd_val = 8'h56;
    s0 = n_starts; d0 = n_done;
    run_cfg("rv_ok");
    chk("rv_ok_starts", n_starts - s0, 1);
    chk("rv_ok_reg",    st_reg[s0[7:0]], 16'h300A);
    chk("rv_ok_flag",   st_wr[s0[7:0]], 1'b1);
    chk("rv_ok_done",   n_done - d0, 1);
    chk("rv_ok_fail",   cfg_fail, 1'b0);

    // read-verify, mismatching: 1 + 3 retries, then fail at index 0
    rd_val = 8'h55;
    s0 = n_starts; d0 = n_done;
    run_cfg("rv_bad");
    chk("rv_bad_starts", n_starts - s0, 4);
    chk("rv_bad_fail",   cfg_fail, 1'b1);
    chk("rv_bad_idx",    fail_idx, 8'h00);
    chk("rv_bad_done",   n_done - d0, 0);

    // NACK twice on index 2, then ACK
    rom[0] = w(2'b00, 16'h0100, 8'h11); rom[1] = w(2'b00, 16'h0101, 8'h22);
    rom[2] = w(2'b00, 16'h0102, 8'h33); rom[3] = w(2'b11, 16'h0000, 8'h00);
    base = m_issue; nack_lo = base + 3; nack_hi = base + 4;
    s0 = n_starts; d0 = n_done;
    run_cfg("nack");
    chk("nack_starts", n_starts - s0, 5);
    chk("nack_last_reg", st_reg[(s0 + 4) & 255], 16'h0102);
    chk("nack_last_dat", st_dat[(s0 + 4) & 255], 8'h33);
    chk("nack_done",   n_done - d0, 1);
    chk("nack_fail",   cfg_fail, 1'b0);
    nack_lo = 1; nack_hi = 0;

    // delay of 10 between writes: start-to-start spacing 22 cycles
    rom[0] = w(2'b00, 16'h0200, 8'hA1); rom[1] = w(2'b10, 16'd10, 8'h00);
    rom[2] = w(2'b00, 16'h0202, 8'hA2); rom[3] = w(2'b11, 16'h0000, 8'h00);
    s0 = n_starts;
    run_cfg("dly10");
    chk("dly10_starts", n_starts - s0, 2);
    gap = st_cyc[(s0 + 1) & 255] - st_cyc[s0[7:0]];
    chk("dly10_gap", gap, 22);

    // delay of 0: no wait cycles, spacing 12
    rom[1] = w(2'b10, 16'd0, 8'h00);
    s0 = n_starts;
    run_cfg("dly0");
    gap = st_cyc[(s0 + 1) & 255] - st_cyc[s0[7:0]];
    chk("dly0_gap", gap, 12);

    // driver never goes busy: 4 attempts of 16 cycles each
    rom[0] = w(2'b00, 16'h0300, 8'h01); rom[1] = w(2'b11, 16'h0000, 8'h00);
    never = 1'b1;
    s0 = n_starts; h0 = se_hi;
    run_cfg("to");
    chk("to_starts", n_starts - s0, 4);
    chk("to_hi_cycles", se_hi - h0, 64);
    chk("to_fail", cfg_fail, 1'b1);
    chk("to_idx",  fail_idx, 8'h00);
    never = 1'b0;

    // reset while waiting for busy to fall on entry 1
    rom[0] = w(2'b00, 16'h0400, 8'h41); rom[1] = w(2'b00, 16'h0401, 8'h42);
    rom[2] = w(2'b11, 16'h0000, 8'h00);
    s0 = n_starts;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (n_starts == s0 + 2 && drv_busy === 1'b1 && drv_start_en === 1'b0) break;
      tick();
    end
    chk("mid_addr", tbl_addr, 8'h01);
    chk("mid_reg",  drv_register, 16'h0401);
    rst_n = 1'b0;
    tick();
    chk("mrst_start_en", drv_start_en, 1'b0);
    chk("mrst_busy",     cfg_busy, 1'b0);
    chk("mrst_done",     cfg_done, 1'b0);
    chk("mrst_fail",     cfg_fail, 1'b0);
    chk("mrst_addr",     tbl_addr, 8'h00);
    chk("mrst_reg",      drv_register, 16'h0000);
    chk("mrst_data",     drv_data_byte, 8'h00);
    chk("mrst_wr",       drv_wr_rd_flag, 1'b0);
    rst_n = 1'b1;
    tick();
    s0 = n_starts; d0 = n_done;
    run_cfg("restart");
    chk("restart_starts", n_starts - s0, 2);
    chk("restart_first",  st_reg[s0[7:0]], 16'h0400);
    chk("restart_done",   n_done - d0, 1);

    // table without end marker wraps and fails at the last index
    fill(w(2'b10, 16'd0, 8'h00));
    s0 = n_starts; d0 = n_done;
    run_cfg("wrap");
    chk("wrap_fail",   cfg_fail, 1'b1);
    chk("wrap_idx",    fail_idx, 8'hFF);
    chk("wrap_starts", n_starts - s0, 0);
    chk("wrap_done",   n_done - d0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
